// File: rtl/seq_mult_32.sv
`default_nettype none
// ============================================================================
// seq_mult_32 : 32x32 unsigned shift-add multiplier, 32 iterations per product
// Revision 1.0
// ============================================================================
module seq_mult_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] R
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mcand;
    logic [63:0] prod;
    logic [5:0]  cnt;
    logic [32:0] sum;
    logic [63:0] prod_step;

    // Upper half accumulates; the 33rd sum bit keeps the carry so the product is exact.
    always_comb begin
        sum       = prod[0] ? ({1'b0, prod[63:32]} + {1'b0, mcand}) : {1'b0, prod[63:32]};
        prod_step = {sum, prod[31:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == 6'd31) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= 32'd0;
            prod  <= 64'd0;
            cnt   <= 6'd0;
            R     <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= A;
                        prod  <= {32'd0, B};
                        cnt   <= 6'd0;
                    end
                end
                S_RUN: begin
                    prod <= prod_step;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        R <= prod_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_32.sv
`default_nettype none
// ============================================================================
// tb_seq_mult_32 : randomized self-checking bench against an arithmetic model
// Revision 1.0
// ============================================================================
module tb_seq_mult_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] R;

    int          checks;
    int          failures;
    int          done_seen;
    int          ops_expected;
    logic [63:0] r_prev;

    seq_mult_32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Caller must be at a negedge; returns at the negedge after the return-to-idle edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input bit scramble);
        logic [63:0] exp;
        bit          run_ok;
        exp    = 64'(a) * 64'(b);
        run_ok = 1'b1;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (scramble) begin
                A = $urandom;
                B = $urandom;
            end
            if (busy !== 1'b1 || done !== 1'b0 || R !== r_prev) begin
                if (run_ok) begin
                    check("run_busy", 64'(busy), 64'd1);
                    check("run_done", 64'(done), 64'd0);
                    check("run_r_hold", R, r_prev);
                end
                run_ok = 1'b0;
            end
        end
        if (run_ok) check("run_window", 64'(busy), 64'd1);
        @(negedge clk);
        check("done_high", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("product", R, exp);
        r_prev = exp;
        ops_expected++;
        @(negedge clk);
        check("done_low", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        bit quiet;
        checks       = 0;
        failures     = 0;
        done_seen    = 0;
        ops_expected = 0;
        r_prev       = 64'd0;
        reset        = 1'b1;
        start        = 1'b0;
        A            = 32'd0;
        B            = 32'd0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_r", R, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op(32'd3, 32'd5, 1'b0, 1'b0);
        check("basic_15", R, 64'h0000_0000_0000_000F);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("max_carry", R, 64'hFFFF_FFFE_0000_0001);
        do_op(32'd0, 32'h1234_5678, 1'b0, 1'b0);
        do_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
        check("pow2_32", R, 64'h0000_0001_0000_0000);

        // start held high with operands changing mid-run
        for (int i = 0; i < 3; i++) begin
            do_op($urandom, $urandom, 1'b1, 1'b1);
        end
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            do_op($urandom, $urandom, 1'b0, (i % 2) == 1);
        end

        // abort mid-run
        A     = 32'hDEAD_BEEF;
        B     = 32'h0BAD_F00D;
        start = 1'b1;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_r", R, 64'd0);
        r_prev = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        check("abort_quiet", 64'(quiet), 64'd1);
        do_op(32'd7, 32'd6, 1'b0, 1'b0);
        check("after_abort_42", R, 64'd42);

        check("done_pulses", 64'(done_seen), 64'(ops_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
